// File: rtl/mini_src_bus_pkg.sv
// Shared definitions for the datapath bus source arbiter: source index codes
// (matching the downstream 32-to-5 select encoder) and the arbiter state type.
package mini_src_bus_pkg;

  localparam int NUM_BUS_SRC = 24;

  typedef logic [4:0] bus_src_idx_t;

  localparam bus_src_idx_t R0     = 5'd0;
  localparam bus_src_idx_t R1     = 5'd1;
  localparam bus_src_idx_t R2     = 5'd2;
  localparam bus_src_idx_t R3     = 5'd3;
  localparam bus_src_idx_t R4     = 5'd4;
  localparam bus_src_idx_t R5     = 5'd5;
  localparam bus_src_idx_t R6     = 5'd6;
  localparam bus_src_idx_t R7     = 5'd7;
  localparam bus_src_idx_t R8     = 5'd8;
  localparam bus_src_idx_t R9     = 5'd9;
  localparam bus_src_idx_t R10    = 5'd10;
  localparam bus_src_idx_t R11    = 5'd11;
  localparam bus_src_idx_t R12    = 5'd12;
  localparam bus_src_idx_t R13    = 5'd13;
  localparam bus_src_idx_t R14    = 5'd14;
  localparam bus_src_idx_t R15    = 5'd15;
  localparam bus_src_idx_t HI     = 5'd16;
  localparam bus_src_idx_t LO     = 5'd17;
  localparam bus_src_idx_t ZHI    = 5'd18;
  localparam bus_src_idx_t ZLO    = 5'd19;
  localparam bus_src_idx_t PC     = 5'd20;
  localparam bus_src_idx_t MDR    = 5'd21;
  localparam bus_src_idx_t INPORT = 5'd22;
  localparam bus_src_idx_t C      = 5'd23;

  typedef enum logic {
    ST_IDLE,
    ST_OWNED
  } arb_state_t;

endpackage

// File: rtl/bus_source_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after
// 'start', ascending and wrapping from N-1 back to 0.
module rr_pick
  import mini_src_bus_pkg::*;
#(
  parameter int N = NUM_BUS_SRC
) (
  input  logic [N-1:0]  req,
  input  bus_src_idx_t  start,
  output logic [N-1:0]  onehot,
  output bus_src_idx_t  idx,
  output logic          valid
);

  int pos;

  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    pos    = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(start) + k) % N;
      if (!valid && req[pos]) begin
        valid = 1'b1;
        idx   = bus_src_idx_t'(pos);
      end
    end
    if (valid) onehot = {{(N-1){1'b0}}, 1'b1} << idx;
  end

endmodule

// File: rtl/bus_source_arbiter.sv
// Round-robin owner of the shared datapath bus with bounded hold time.
// Optional BUS_LOCK_EN adds a 'lock' input that suppresses forced rotation.
module bus_source_arbiter
  import mini_src_bus_pkg::*;
#(
  parameter int NUM_SRC  = NUM_BUS_SRC,
  parameter int MAX_HOLD = 4
) (
  input  logic               clock,
  input  logic               clear,
`ifdef BUS_LOCK_EN
  input  logic               lock,
`endif
  input  logic [NUM_SRC-1:0] req,
  output logic [NUM_SRC-1:0] gnt,
  output logic [4:0]         gnt_idx,
  output logic               bus_busy,
  output logic [2:0]         hold_cnt
);

  arb_state_t         state;
  bus_src_idx_t       rr_ptr;
  bus_src_idx_t       start;
  logic [NUM_SRC-1:0] pick_onehot;
  bus_src_idx_t       pick_idx;
  logic               pick_valid;
  logic               owner_req;
  logic               lock_hold;
  logic               keep;

  // The current owner is masked out, so a valid pick always means "someone else wants it".
  assign start     = (rr_ptr == bus_src_idx_t'(NUM_SRC-1)) ? '0 : rr_ptr + 5'd1;
  assign owner_req = |(req & gnt);

`ifdef BUS_LOCK_EN
  assign lock_hold = lock;
`else
  assign lock_hold = 1'b0;
`endif

  assign keep = (state == ST_OWNED) && owner_req &&
                ((int'(hold_cnt) + 1 < MAX_HOLD) || !pick_valid || lock_hold);

  rr_pick #(.N(NUM_SRC)) u_pick (
    .req    (req & ~gnt),
    .start  (start),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_ff @(posedge clock) begin
    if (!clear) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      gnt_idx  <= '0;
      bus_busy <= 1'b0;
      hold_cnt <= '0;
      rr_ptr   <= bus_src_idx_t'(NUM_SRC-1);
    end else if (keep) begin
      if (hold_cnt < 3'(MAX_HOLD)) hold_cnt <= hold_cnt + 3'd1;
    end else if (pick_valid) begin
      state    <= ST_OWNED;
      gnt      <= pick_onehot;
      gnt_idx  <= pick_idx;
      bus_busy <= 1'b1;
      hold_cnt <= '0;
      rr_ptr   <= pick_idx;
    end else begin
      state    <= ST_IDLE;
      gnt      <= '0;
      gnt_idx  <= '0;
      bus_busy <= 1'b0;
      hold_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Self-checking bench for bus_source_arbiter: directed scenarios plus random
// traffic against an owner/pointer/hold reference model. Define BUS_LOCK_EN to test lock.
module tb_bus_source_arbiter;

  localparam int N   = 24;
  localparam int MAX = 4;

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic          lock  = 1'b0;
  logic [N-1:0]  req   = '0;
  logic [N-1:0]  gnt;
  logic [4:0]    gnt_idx;
  logic          bus_busy;
  logic [2:0]    hold_cnt;

  int compared   = 0;
  int mismatched = 0;

  int m_owner = -1;
  int m_ptr   = N - 1;
  int m_hold  = 0;

  bus_source_arbiter dut (
    .clock    (clock),
    .clear    (clear),
`ifdef BUS_LOCK_EN
    .lock     (lock),
`endif
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .bus_busy (bus_busy),
    .hold_cnt (hold_cnt)
  );

  always #5 clock = ~clock;

  // At most one driver on the bus, checked every cycle.
  always @(negedge clock) begin
    compared++;
    if (!$onehot0(gnt)) begin
      mismatched++;
      $display("[TB] FAIL onehot0 gnt=%h", gnt);
    end
  end

  function automatic logic [N-1:0] exp_gnt();
    return (m_owner < 0) ? '0 : (24'd1 << m_owner);
  endfunction

  function automatic logic [4:0] exp_idx();
    return (m_owner < 0) ? 5'd0 : 5'(m_owner);
  endfunction

  // Reference: an owner keeps the bus while requesting unless it has used its
  // quota and someone else waits; otherwise the next requester after the pointer wins.
  task automatic model_step(input logic [N-1:0] r, input logic c, input logic lk);
    bit others = 0;
    bit keep   = 0;
    int win    = -1;
    if (!c) begin
      m_owner = -1; m_ptr = N - 1; m_hold = 0;
      return;
    end
    for (int i = 0; i < N; i++) if (r[i] && i != m_owner) others = 1;
    if (m_owner >= 0) begin
      if (r[m_owner] && (m_hold + 1 < MAX || !others || lk)) keep = 1;
    end
    if (keep) begin
      if (m_hold < MAX) m_hold++;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int i = (m_ptr + k) % N;
        if (win < 0 && r[i] && i != m_owner) win = i;
      end
      m_hold = 0;
      if (win >= 0) begin
        m_owner = win; m_ptr = win;
      end else m_owner = -1;
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic c);
    @(negedge clock);
    req   = r;
    clear = c;
`ifdef BUS_LOCK_EN
    model_step(r, c, lock);
`else
    model_step(r, c, 1'b0);
`endif
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      applyStimulus('1, 1'b0);
      compared += 4;
      if (gnt !== '0)      begin mismatched++; $display("[TB] FAIL reset_gnt got=%h want=0", gnt); end
      if (bus_busy !== 0)  begin mismatched++; $display("[TB] FAIL reset_busy got=%b want=0", bus_busy); end
      if (gnt_idx !== 0)   begin mismatched++; $display("[TB] FAIL reset_idx got=%0d want=0", gnt_idx); end
      if (hold_cnt !== 0)  begin mismatched++; $display("[TB] FAIL reset_hold got=%0d want=0", hold_cnt); end
    end
    applyStimulus('1, 1'b1);
    compared += 3;
    if (gnt !== 24'h000001) begin mismatched++; $display("[TB] FAIL release_gnt got=%h want=000001", gnt); end
    if (gnt_idx !== 0)      begin mismatched++; $display("[TB] FAIL release_idx got=%0d want=0", gnt_idx); end
    if (bus_busy !== 1)     begin mismatched++; $display("[TB] FAIL release_busy got=%b want=1", bus_busy); end
  endtask

  task automatic test_single();
    applyStimulus('0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(24'h100000, 1'b1);
      compared += 3;
      if (gnt !== 24'h100000) begin mismatched++; $display("[TB] FAIL single_gnt cyc=%0d got=%h want=100000", i, gnt); end
      if (gnt_idx !== 5'd20)  begin mismatched++; $display("[TB] FAIL single_idx cyc=%0d got=%0d want=20", i, gnt_idx); end
      if (hold_cnt !== 3'(i)) begin mismatched++; $display("[TB] FAIL single_hold cyc=%0d got=%0d want=%0d", i, hold_cnt, i); end
    end
    applyStimulus('0, 1'b1);
    compared += 2;
    if (gnt !== '0)     begin mismatched++; $display("[TB] FAIL single_idle_gnt got=%h want=0", gnt); end
    if (bus_busy !== 0) begin mismatched++; $display("[TB] FAIL single_idle_busy got=%b want=0", bus_busy); end
  endtask

  task automatic test_round_robin();
    int seq [12] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1};
    for (int i = 0; i < 12; i++) begin
      applyStimulus(24'h000006, 1'b1);
      compared += 2;
      if (gnt_idx !== 5'(seq[i])) begin mismatched++; $display("[TB] FAIL rr_idx cyc=%0d got=%0d want=%0d", i, gnt_idx, seq[i]); end
      if (hold_cnt !== 3'(i % 4)) begin mismatched++; $display("[TB] FAIL rr_hold cyc=%0d got=%0d want=%0d", i, hold_cnt, i % 4); end
    end
  endtask

  task automatic test_wrap();
    applyStimulus('0, 1'b1);
    applyStimulus(24'h800000, 1'b1);
    compared++;
    if (gnt_idx !== 5'd23) begin mismatched++; $display("[TB] FAIL wrap_owner got=%0d want=23", gnt_idx); end
    applyStimulus(24'h400001, 1'b1);
    compared += 2;
    if (gnt_idx !== 5'd0)   begin mismatched++; $display("[TB] FAIL wrap_idx got=%0d want=0", gnt_idx); end
    if (gnt !== 24'h000001) begin mismatched++; $display("[TB] FAIL wrap_gnt got=%h want=000001", gnt); end
  endtask

  task automatic test_back_to_back();
    applyStimulus('0, 1'b1);
    applyStimulus(24'h000020, 1'b1);
    compared++;
    if (gnt !== 24'h000020) begin mismatched++; $display("[TB] FAIL b2b_first got=%h want=000020", gnt); end
    applyStimulus(24'h000080, 1'b1);
    compared += 2;
    if (gnt !== 24'h000080) begin mismatched++; $display("[TB] FAIL b2b_second got=%h want=000080", gnt); end
    if (bus_busy !== 1)     begin mismatched++; $display("[TB] FAIL b2b_busy got=%b want=1", bus_busy); end
  endtask

  task automatic test_reset_mid();
    applyStimulus('0, 1'b1);
    applyStimulus(24'h010000, 1'b1);
    compared++;
    if (gnt_idx !== 5'd16) begin mismatched++; $display("[TB] FAIL mid_owner got=%0d want=16", gnt_idx); end
    applyStimulus(24'h030000, 1'b0);
    compared += 2;
    if (gnt !== '0)     begin mismatched++; $display("[TB] FAIL mid_reset_gnt got=%h want=0", gnt); end
    if (hold_cnt !== 0) begin mismatched++; $display("[TB] FAIL mid_reset_hold got=%0d want=0", hold_cnt); end
    applyStimulus(24'h030000, 1'b1);
    compared++;
    if (gnt_idx !== 5'd16) begin mismatched++; $display("[TB] FAIL mid_rewin got=%0d want=16", gnt_idx); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r = '0;
      int dens = $urandom_range(1, 4);
      for (int b = 0; b < N; b++) r[b] = ($urandom_range(0, 15) < dens);
      if ($urandom_range(0, 3) == 0) r = req;
      applyStimulus(r, ($urandom_range(0, 59) != 0));
      compared += 4;
      if (gnt !== exp_gnt())       begin mismatched++; $display("[TB] FAIL rand_gnt cyc=%0d got=%h want=%h", i, gnt, exp_gnt()); end
      if (gnt_idx !== exp_idx())   begin mismatched++; $display("[TB] FAIL rand_idx cyc=%0d got=%0d want=%0d", i, gnt_idx, exp_idx()); end
      if (bus_busy !== (m_owner >= 0)) begin mismatched++; $display("[TB] FAIL rand_busy cyc=%0d got=%b want=%b", i, bus_busy, m_owner >= 0); end
      if (hold_cnt !== 3'(m_hold)) begin mismatched++; $display("[TB] FAIL rand_hold cyc=%0d got=%0d want=%0d", i, hold_cnt, m_hold); end
    end
  endtask

`ifdef BUS_LOCK_EN
  task automatic test_lock();
    applyStimulus('0, 1'b0);
    lock = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(24'h000006, 1'b1);
      compared += 2;
      if (gnt_idx !== 5'd1) begin mismatched++; $display("[TB] FAIL lock_idx cyc=%0d got=%0d want=1", i, gnt_idx); end
      if (hold_cnt !== 3'(i < MAX ? i : MAX)) begin mismatched++; $display("[TB] FAIL lock_hold cyc=%0d got=%0d", i, hold_cnt); end
    end
    lock = 1'b0;
    applyStimulus(24'h000006, 1'b1);
    compared++;
    if (gnt_idx !== 5'd2) begin mismatched++; $display("[TB] FAIL unlock_idx got=%0d want=2", gnt_idx); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
`ifdef BUS_LOCK_EN
    test_lock();
`endif
    test_random();
    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
